alu_result_sel_pipe: RTL and testbench

//   Registered, parametrised ALU result selector with valid/ready handshake.

---
 rtl/alu_result_sel_pipe.sv | 127 ++++++++++++
 tb/tb_alu_result_sel_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_sel_pipe.sv
// Registered ALU result selector: picks CLA, SLT or multi-cycle modulo result
// and presents it to writeback through a single valid/ready output slot.
module alu_result_sel_pipe #(
   parameter int         WIDTH  = 32,
   parameter logic [2:0] OP_SLT = 3'b100,
   parameter logic [2:0] OP_MOD = 3'b111
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] cla_result,
   input  logic             slt,
   output logic             mod_start,
   input  logic             mod_done,
   input  logic [WIDTH-1:0] mod_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [2:0]       out_op,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
   // valid may not depend on ready, and producers hold their data until the transfer.

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_MOD = 2'd1;
   localparam logic [1:0] ST_HOLD     = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_result_q, out_result_d;
   logic [2:0]       out_op_q, out_op_d;
   logic             mod_start_q, mod_start_d;
   logic [WIDTH-1:0] hold_buf_q, hold_buf_d;

   logic             slot_free;
   logic             accept;
   logic [WIDTH-1:0] sel_result;

   always_comb begin
      sel_result = cla_result;
      if (alu_op == OP_SLT) begin
         sel_result = {{(WIDTH-1){1'b0}}, slt};
      end
   end

   always_comb begin
      slot_free    = !out_valid_q || out_ready;
      in_ready     = (state_q == ST_IDLE) && slot_free;
      accept       = in_valid && in_ready;
      state_d      = state_q;
      // The slot empties whenever writeback takes it; loads below refill it.
      out_valid_d  = out_valid_q && !out_ready;
      out_result_d = out_result_q;
      out_op_d     = out_op_q;
      mod_start_d  = 1'b0;
      hold_buf_d   = hold_buf_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (alu_op == OP_MOD) begin
                  mod_start_d = 1'b1;
                  state_d     = ST_WAIT_MOD;
               end else begin
                  out_result_d = sel_result;
                  out_op_d     = alu_op;
                  out_valid_d  = 1'b1;
               end
            end
         end
         ST_WAIT_MOD: begin
            if (mod_done) begin
               if (slot_free) begin
                  out_result_d = mod_result;
                  out_op_d     = OP_MOD;
                  out_valid_d  = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  hold_buf_d = mod_result;
                  state_d    = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (slot_free) begin
               out_result_d = hold_buf_q;
               out_op_d     = OP_MOD;
               out_valid_d  = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_op_q     <= '0;
         mod_start_q  <= 1'b0;
         hold_buf_q   <= '0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_op_q     <= out_op_d;
         mod_start_q  <= mod_start_d;
         hold_buf_q   <= hold_buf_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_op     = out_op_q;
   assign mod_start  = mod_start_q;
   assign busy       = (state_q != ST_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Bench for alu_result_sel_pipe: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_alu_result_sel_pipe;

   localparam int W = 32;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_MOD = 3'b111;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    alu_op;
   logic [W-1:0]  cla_result;
   logic          slt;
   logic          mod_start;
   logic          mod_done;
   logic [W-1:0]  mod_result;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic [2:0]    out_op;
   logic          busy;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   alu_result_sel_pipe #(.WIDTH(W), .OP_SLT(OP_SLT), .OP_MOD(OP_MOD)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .cla_result(cla_result), .slt(slt),
      .mod_start(mod_start), .mod_done(mod_done), .mod_result(mod_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_op(out_op), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // model: results accepted but not yet taken by writeback, oldest first
   logic [W+2:0] exp_q[$];
   bit m_out_valid, m_wait, m_held, m_start;

   always @(negedge clk) begin
      bit slot_free, nxt_valid, nxt_start;
      logic [W-1:0] sel;
      if (!rst_n) begin
         exp_q.delete();
         m_out_valid = 0; m_wait = 0; m_held = 0; m_start = 0;
      end else begin
         slot_free = !m_out_valid || out_ready;
         check("m_in_ready", W'(in_ready), W'(!m_wait && !m_held && slot_free));
         check("m_out_valid", W'(out_valid), W'(m_out_valid));
         check("m_mod_start", W'(mod_start), W'(m_start));
         check("m_busy", W'(busy), W'(m_wait || m_held));
         if (m_out_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL m_queue: got empty expected entry at %0t", $time);
            end else begin
               check("m_out_result", out_result, exp_q[0][W-1:0]);
               check("m_out_op", W'(out_op), W'(exp_q[0][W+2:W]));
            end
         end
         nxt_valid = m_out_valid && !out_ready;
         if (m_out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         nxt_start = 0;
         if (!m_wait && !m_held) begin
            if (in_valid && slot_free) begin
               if (alu_op == OP_MOD) begin
                  m_wait = 1; nxt_start = 1;
               end else begin
                  sel = (alu_op == OP_SLT) ? W'(slt) : cla_result;
                  exp_q.push_back({alu_op, sel});
                  nxt_valid = 1;
               end
            end
         end else if (m_wait) begin
            if (mod_done) begin
               exp_q.push_back({OP_MOD, mod_result});
               m_wait = 0;
               if (slot_free) nxt_valid = 1;
               else m_held = 1;
            end
         end else if (slot_free) begin
            nxt_valid = 1; m_held = 0;
         end
         m_out_valid = nxt_valid;
         m_start = nxt_start;
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic drive_in(input logic v, input logic [2:0] op, input logic [W-1:0] cla, input logic s);
      in_valid = v; alu_op = op; cla_result = cla; slt = s;
   endtask

   initial begin
      rst_n = 1'b0;
      drive_in(1'b1, 3'b000, 32'd77, 1'b0);
      mod_done = 1'b0; mod_result = '0; out_ready = 1'b0;

      // reset state with in_valid high
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", W'(out_valid), 0);
      check("rst_out_result", out_result, 0);
      check("rst_mod_start", W'(mod_start), 0);
      check("rst_out_op", W'(out_op), 0);
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      check("rst_in_ready", W'(in_ready), 1);

      // ADD stream
      cyc();
      out_ready = 1'b1;
      drive_in(1'b1, 3'b000, 32'd5, 1'b0);
      cyc(); drive_in(1'b1, 3'b000, 32'd6, 1'b0);
      @(negedge clk); check("add_0", out_result, 32'd5);
      cyc(); drive_in(1'b1, 3'b000, 32'd7, 1'b0);
      @(negedge clk); check("add_1", out_result, 32'd6);
      cyc(); in_valid = 1'b0;
      @(negedge clk); check("add_2", out_result, 32'd7);

      // SLT zero-extends the comparator bit
      cyc(); drive_in(1'b1, OP_SLT, 32'hFFFF_FFFF, 1'b1);
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      check("slt_result", out_result, 32'h0000_0001);
      check("slt_op", W'(out_op), W'(OP_SLT));

      // modulo op with free slot
      cyc(); drive_in(1'b1, OP_MOD, 32'h1234, 1'b0);
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      check("mod_start_pulse", W'(mod_start), 1);
      check("mod_in_ready_0", W'(in_ready), 0);
      cyc(); @(negedge clk);
      check("mod_start_once", W'(mod_start), 0);
      check("mod_in_ready_1", W'(in_ready), 0);
      cyc(); cyc();
      mod_done = 1'b1; mod_result = 32'd3;
      cyc(); mod_done = 1'b0; mod_result = 32'hDEAD;
      @(negedge clk);
      check("mod_result", out_result, 32'd3);
      check("mod_op", W'(out_op), W'(OP_MOD));
      check("mod_valid", W'(out_valid), 1);

      // modulo op behind a stalled ADD result
      cyc(); out_ready = 1'b0;
      drive_in(1'b1, 3'b000, 32'd9, 1'b0);
      cyc(); drive_in(1'b1, OP_MOD, 32'h55, 1'b0);
      @(negedge clk);
      check("bp_in_ready", W'(in_ready), 0);
      cyc(); cyc();
      @(negedge clk);
      check("bp_stable", out_result, 32'd9);
      check("bp_busy", W'(busy), 0);
      cyc(); out_ready = 1'b1;
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      check("bp_drained", W'(out_valid), 0);
      check("bp_busy_wait", W'(busy), 1);
      cyc(); mod_done = 1'b1; mod_result = 32'd2;
      cyc(); mod_done = 1'b0;
      @(negedge clk);
      check("bp_mod_result", out_result, 32'd2);
      cyc(); @(negedge clk);
      check("bp_ready_back", W'(in_ready), 1);

      // reset while waiting for the modulo unit, then a stray mod_done
      cyc(); drive_in(1'b1, OP_MOD, 32'h0, 1'b0);
      cyc(); in_valid = 1'b0;
      cyc(); rst_n = 1'b0;
      cyc(); rst_n = 1'b1; mod_done = 1'b1; mod_result = 32'd55;
      cyc(); mod_done = 1'b0;
      @(negedge clk);
      check("rstw_state", W'(dbg_state), 0);
      check("rstw_out_valid", W'(out_valid), 0);
      check("rstw_busy", W'(busy), 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if (i % 700 == 350) rst_n = 1'b0;
         else rst_n = 1'b1;
         drive_in($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) alu_op = OP_MOD;
         out_ready = $urandom_range(0, 9) < 7;
         mod_done = $urandom_range(0, 3) == 0;
         mod_result = $urandom;
      end
      cyc(); rst_n = 1'b1; in_valid = 1'b0; mod_done = 1'b0; out_ready = 1'b1;
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
